// File: rtl/uart_rx_pkg.sv
// UART receive controller shared types.
// State encoding and frame constants.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CHECK
  } state_t;

  localparam int         DATA_BITS      = 8;
  localparam logic [5:0] PRESCALE_RESET = 6'd8;

endpackage

// File: rtl/uart_rx_if.sv
// UART receive controller bus bundle.
// Line, counter, sampler and result signals.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 rx_in;
  logic                 par_en;
  logic                 par_typ;
  logic [5:0]           Prescale;
  logic [4:0]           edge_cnt;
  logic [3:0]           bit_cnt;
  logic                 sampled_bit;
  logic                 cnt_enable;
  logic                 dat_samp_en;
  logic [DATA_BITS-1:0] P_DATA;
  logic                 data_valid;
  logic                 par_err;
  logic                 stp_err;
  logic                 strt_glitch;

  modport master (
    output rx_in, par_en, par_typ, Prescale,
    output edge_cnt, bit_cnt, sampled_bit,
    input  cnt_enable, dat_samp_en, P_DATA,
    input  data_valid, par_err, stp_err, strt_glitch
  );

  modport slave (
    input  rx_in, par_en, par_typ, Prescale,
    input  edge_cnt, bit_cnt, sampled_bit,
    output cnt_enable, dat_samp_en, P_DATA,
    output data_valid, par_err, stp_err, strt_glitch
  );

endinterface

// File: rtl/uart_rx_deser.sv
// LSB-first deserializer for received data bits.
// Exposes the byte and its XOR parity.
module uart_rx_deser
  import uart_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 sampled_bit,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  // shift right, newest bit enters at the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data <= '0;
    else if (shift_en)
      data <= {sampled_bit, data[DATA_BITS-1:1]};
  end

  assign parity = ^data;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive frame controller.
// Sequences start/data/parity/stop and flags errors.
module uart_rx_controller
  import uart_rx_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  state_t               state_q, state_d;
  logic [5:0]           pre_q;
  logic                 rx_prev;
  logic                 par_flag;
  logic                 stp_flag;
  logic                 bit_end;
  logic                 shift_en;
  logic                 busy;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_x;
  logic [DATA_BITS-1:0] p_data_q;
  logic                 dv_q, pe_q, se_q, sg_q;
  logic                 flags_clr;

  assign bit_end   = ({1'b0, bus.edge_cnt} == (pre_q - 6'd1));
  assign shift_en  = (state_q == S_DATA) && bit_end;
  assign flags_clr = !par_flag && !stp_flag;
  assign busy      = (state_q == S_START) || (state_q == S_DATA)
                  || (state_q == S_PARITY) || (state_q == S_STOP);

  uart_rx_deser u_deser (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .sampled_bit (bus.sampled_bit),
    .data        (shreg),
    .parity      (par_x)
  );

  // next-state decode; IDLE needs a fresh falling edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx_prev && !bus.rx_in)
          state_d = S_START;
      S_START:
        if (bit_end)
          state_d = bus.sampled_bit ? S_IDLE : S_DATA;
      S_DATA:
        if (bit_end && bus.bit_cnt == 4'(DATA_BITS))
          state_d = bus.par_en ? S_PARITY : S_STOP;
      S_PARITY:
        if (bit_end)
          state_d = S_STOP;
      S_STOP:
        if (bit_end)
          state_d = S_CHECK;
      S_CHECK:
        state_d = bus.rx_in ? S_IDLE : S_START;
      default:
        state_d = S_IDLE;
    endcase
  end

  // state, latched prescale and line history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= PRESCALE_RESET;
      rx_prev <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_prev <= bus.rx_in;
      if (state_q == S_IDLE && state_d == S_START)
        pre_q <= bus.Prescale;
    end
  end

  // parity/stop error flags, cleared as CHECK is left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else if (state_q == S_CHECK) begin
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else begin
      if (state_q == S_PARITY && bit_end)
        par_flag <= bus.sampled_bit != (par_x ^ bus.par_typ);
      if (state_q == S_STOP && bit_end)
        stp_flag <= ~bus.sampled_bit;
    end
  end

  // registered result byte and one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data_q <= '0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      se_q     <= 1'b0;
      sg_q     <= 1'b0;
    end else begin
      dv_q <= (state_q == S_CHECK) && flags_clr;
      pe_q <= (state_q == S_CHECK) && par_flag;
      se_q <= (state_q == S_CHECK) && stp_flag;
      sg_q <= (state_q == S_START) && bit_end
           && bus.sampled_bit;
      if (state_q == S_CHECK && flags_clr)
        p_data_q <= shreg;
    end
  end

  assign bus.cnt_enable  = busy;
  assign bus.dat_samp_en = busy;
  assign bus.P_DATA      = p_data_q;
  assign bus.data_valid  = dv_q;
  assign bus.par_err     = pe_q;
  assign bus.stp_err     = se_q;
  assign bus.strt_glitch = sg_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller.
// Models the edge/bit counter and mid-bit sampler.
module tb_uart_rx_controller;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cnt_pre;
  int   checks = 0;
  int   errors = 0;
  int   dv_n = 0, pe_n = 0, se_n = 0;
  int   sg_n = 0, ovl_n = 0;
  int   base;
  logic [7:0] dv_log[$];

  uart_rx_if bus ();

  uart_rx_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // edge/bit counter model
  always @(posedge clk or posedge rst) begin
    if (rst || !bus.cnt_enable) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= '0;
    end else if (bus.edge_cnt == 5'(cnt_pre - 1)) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 5'd1;
    end
  end

  // sampler model: take the line at mid-bit
  always @(posedge clk or posedge rst) begin
    if (rst)
      bus.sampled_bit <= 1'b1;
    else if (bus.dat_samp_en
          && bus.edge_cnt == 5'(cnt_pre / 2))
      bus.sampled_bit <= bus.rx_in;
  end

  // pulse monitor
  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_n++;
      dv_log.push_back(bus.P_DATA);
    end
    if (bus.par_err) pe_n++;
    if (bus.stp_err) se_n++;
    if (bus.strt_glitch) sg_n++;
    if (bus.data_valid
        && (bus.par_err || bus.stp_err || bus.strt_glitch))
      ovl_n++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    repeat (cnt_pre) begin
      @(negedge clk);
      bus.rx_in = v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic par_on,
                            input logic par_v,
                            input logic stop_v,
                            input logic [5:0] pnew);
    drive_bit(1'b0);
    if (pnew != 6'd0) bus.Prescale = pnew;
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (par_on) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_in    = 1'b0;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.Prescale = 6'd8;
    cnt_pre      = 8;
    repeat (3) @(negedge clk);
    chk("rst_cnt_en", 32'(bus.cnt_enable), 0);
    chk("rst_samp_en", 32'(bus.dat_samp_en), 0);
    chk("rst_pdata", 32'(bus.P_DATA), 0);
    chk("rst_pulses", 32'({bus.data_valid, bus.par_err,
                           bus.stp_err, bus.strt_glitch}), 0);

    // line held low through reset: no frame
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_start_low_line", 32'(bus.cnt_enable), 0);
    idle(4);

    // 0xA5, prescale 8, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 6'd0);
    idle(8);
    chk("a5_dv", dv_n, 1);
    chk("a5_pdata", 32'(bus.P_DATA), 32'hA5);
    chk("a5_noerr", pe_n + se_n + sg_n, 0);
    chk("a5_cnt_off", 32'(bus.cnt_enable), 0);

    // 0x3C even parity, wrong parity bit
    bus.Prescale = 6'd16;
    cnt_pre      = 16;
    bus.par_en   = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 6'd0);
    idle(8);
    chk("par_err_n", pe_n, 1);
    chk("par_no_dv", dv_n, 1);
    chk("par_pdata_hold", 32'(bus.P_DATA), 32'hA5);

    // 0x3C odd parity, bit 1 is correct
    bus.par_typ = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 6'd0);
    idle(8);
    chk("odd_dv", dv_n, 2);
    chk("odd_pdata", 32'(bus.P_DATA), 32'h3C);
    chk("odd_par_err_n", pe_n, 1);

    // start glitch at prescale 32
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.Prescale = 6'd32;
    cnt_pre      = 32;
    repeat (4) begin
      @(negedge clk);
      bus.rx_in = 1'b0;
    end
    idle(40);
    chk("glitch_n", sg_n, 1);
    chk("glitch_cnt_off", 32'(bus.cnt_enable), 0);
    chk("glitch_no_dv", dv_n, 2);

    // 0x55 with bad stop bit
    bus.Prescale = 6'd8;
    cnt_pre      = 8;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 6'd0);
    idle(8);
    chk("stp_err_n", se_n, 1);
    chk("stp_no_dv", dv_n, 2);
    chk("stp_pdata_hold", 32'(bus.P_DATA), 32'h3C);

    // back-to-back 0x01 then 0xFE
    base = dv_log.size();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 6'd0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 6'd0);
    idle(10);
    chk("b2b_dv", dv_n, 4);
    chk("b2b_first", 32'(dv_log[base]), 32'h01);
    chk("b2b_second", 32'(dv_log[base + 1]), 32'hFE);

    // prescale port moves mid-frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 6'd16);
    idle(8);
    bus.Prescale = 6'd8;
    chk("pre_ign_dv", dv_n, 5);
    chk("pre_ign_pdata", 32'(bus.P_DATA), 32'h5A);

    // reset during DATA of 0xFF
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cnt_en", 32'(bus.cnt_enable), 0);
    chk("mid_rst_samp_en", 32'(bus.dat_samp_en), 0);
    chk("mid_rst_pdata", 32'(bus.P_DATA), 0);
    chk("mid_rst_pulses", 32'({bus.data_valid, bus.par_err,
                               bus.stp_err, bus.strt_glitch}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4);
    chk("post_rst_idle", 32'(bus.cnt_enable), 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 6'd0);
    idle(8);
    chk("post_rst_dv", dv_n, 6);
    chk("post_rst_pdata", 32'(bus.P_DATA), 32'h81);

    chk("no_overlap", ovl_n, 0);
    chk("total_par_err", pe_n, 1);
    chk("total_stp_err", se_n, 1);
    chk("total_glitch", sg_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 rx_in  input  1  raw serial line, idle high.
REQ-004 par_en  input  1  1 = frame carries a parity bit.
REQ-005 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-006 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 edge_cnt  input  5  edge count within the current bit, from the edge/bit counter.
REQ-008 bit_cnt  input  4  bit index within the frame, from the edge/bit counter (start bit = 0).
REQ-009 sampled_bit  input  1  majority-voted bit from the data sampler; valid at bit end.
REQ-010 cnt_enable  output  1  enable to the edge/bit counter.
REQ-011 dat_samp_en  output  1  enable to the data sampler.
REQ-012 P_DATA  output  8  received byte.
REQ-013 data_valid  output  1  one-cycle pulse; P_DATA holds a good byte.
REQ-014 par_err, stp_err, strt_glitch  output  1 each  one-cycle error pulses.

Function
REQ-015 States: IDLE, START, DATA, PARITY, STOP, CHECK.
REQ-016 Bit end is the cycle where edge_cnt == Prescale_q - 1.
- Prescale_q is Prescale latched on IDLE->START.
- Changes to Prescale mid-frame are ignored.
REQ-017 IDLE: rx_in == 0 -> START; otherwise stay.
REQ-018 START, at bit end:
- sampled_bit == 0 -> DATA.
- sampled_bit == 1 -> IDLE with strt_glitch pulsed for one cycle.
REQ-019 DATA, at each bit end: shift sampled_bit in LSB-first (shift right, insert at bit 7).
- At the bit end with bit_cnt == 8: go to PARITY if par_en, else STOP.
REQ-020 PARITY, at bit end:
- Expected bit = XOR of shift register, inverted when par_typ == 1.
- Mismatch sets an internal par_flag.
- Next state STOP.
REQ-021 STOP, at bit end: stp_flag = ~sampled_bit; next state CHECK.
REQ-022 CHECK lasts exactly one cycle:
- No flags set: P_DATA <= shift register and data_valid = 1.
- Otherwise par_err and/or stp_err pulse and P_DATA is unchanged.
- Next state is START if rx_in == 0 (back-to-back frame), else IDLE.
- Flags clear on leaving CHECK.
REQ-023 cnt_enable = dat_samp_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE and CHECK.
- These outputs are decoded combinationally from the state register.
- The 0 in CHECK clears the counter between frames.
REQ-024 data_valid, par_err, stp_err and strt_glitch are registered, high for one cycle only, and never asserted together with data_valid.
REQ-025 P_DATA holds its value until the next error-free frame.
REQ-026 par_en and par_typ are sampled at the PARITY bit end; they are not latched.
REQ-027 rx_in is not re-examined between START and CHECK; only sampled_bit is used.

Reset
REQ-028 Asserting rst, including mid-frame, forces the following immediately and asynchronously:
- state IDLE; shift register, P_DATA and flags 0; Prescale_q 8.
- every output 0.
REQ-029 After rst deasserts, the first frame is accepted only from a new falling edge of rx_in seen in IDLE.

Structure
REQ-030 A shared package uart_rx_pkg holds:
- the state enumeration (3-bit encoding);
- the constants DATA_BITS = 8 and PRESCALE_RESET = 8.
REQ-031 One sub-module, uart_rx_deser, contains the 8-bit shift register and its parity XOR.
- Its inputs are clk, rst, shift_en and sampled_bit.
- Its outputs are data and parity.
REQ-032 FSM next-state logic and output registering stay in uart_rx_controller.

Verification
REQ-033 Prescale=8, par_en=0, frame 0xA5 with good stop -> P_DATA=0xA5, one data_valid pulse, no error pulses.
REQ-034 Prescale=16, par_en=1, par_typ=0, byte 0x3C with parity bit 1 -> par_err pulse once, data_valid=0, P_DATA unchanged.
REQ-035 Prescale=32, rx_in low for 4 cycles then high -> strt_glitch pulse at start-bit end, return to IDLE, cnt_enable low.
REQ-036 Prescale=8, byte 0x55 with stop bit 0 -> stp_err pulse, no data_valid.
REQ-037 Back-to-back frames 0x01 then 0xFE, new start bit immediately after the stop bit -> two data_valid pulses, P_DATA 0x01 then 0xFE.
REQ-038 rst asserted during DATA of a 0xFF frame -> all outputs 0 at once; the following clean 0x81 frame is received correctly.
